ds_pool_engine: RTL and testbench

- Downstream neighbour of the data RAM. Consumes the image already loaded into data memory and produces the downsampled image.
- Performs 2x2 block pooling (rounded average) over an IMG_W x IMG_H 8-bit image stored at SRC_BASE.
- Writes the (IMG_W/2) x (IMG_H/2) result back to data memory at DST_BASE.
- Drives the data RAM addr/read/write/din/dout port pair directly; sequenced by start/busy/done from the controller.

---
 rtl/ds_pool_engine.sv | 132 +++++++++++++
 tb/tb_ds_pool_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ds_pool_engine.sv
// 2x2 block pooling engine: reads an IMG_W x IMG_H 8-bit image from data RAM and writes the
// half-size image back. Default is rounded-average pooling; define DS_MAX_POOL_EN for max pooling.
module ds_pool_engine #(
  parameter int          IMG_W    = 128,
  parameter int          IMG_H    = 128,
  parameter logic [15:0] SRC_BASE = 16'h0000,
  parameter logic [15:0] DST_BASE = 16'h4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] out_cnt,
  output logic [15:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int          OW      = IMG_W / 2;
  localparam int          OH      = IMG_H / 2;
  localparam logic [15:0] W16     = 16'(IMG_W);
  localparam logic [15:0] OW16    = 16'(OW);
  localparam logic [15:0] OX_LAST = 16'(OW - 1);
  localparam logic [15:0] OY_LAST = 16'(OH - 1);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] ox, oy;
  logic [1:0]  k;
  logic [9:0]  acc, acc_in;
  logic [7:0]  result;
  logic [15:0] src_addr, dst_addr;
  logic        last;

  // Tap k selects dx=k[0], dy=k[1]; all sums wrap modulo 2^16.
  assign src_addr = SRC_BASE + ({oy[14:0], 1'b0} + {15'd0, k[1]}) * W16
                  + {ox[14:0], 1'b0} + {15'd0, k[0]};
  assign dst_addr = DST_BASE + oy * OW16 + ox;
  assign last     = (ox == OX_LAST) && (oy == OY_LAST);

`ifdef DS_MAX_POOL_EN
  assign acc_in = ({2'b00, mem_rdata} > acc) ? {2'b00, mem_rdata} : acc;
  assign result = acc[7:0];
`else
  logic [9:0] rnd;
  assign acc_in = acc + {2'b00, mem_rdata};
  assign rnd    = acc + 10'd2;   // at most 1022, fits
  assign result = rnd[9:2];
`endif

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 8'd0;
    case (state)
      IDLE: if (start) state_nx = RD;
      RD: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = src_addr;
        if (k == 2'd3) state_nx = CAP;
      end
      CAP: begin
        busy     = 1'b1;
        state_nx = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = dst_addr;
        mem_wdata = result;
        state_nx  = last ? DONE : RD;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_cnt <= 16'd0;
      acc     <= 10'd0;
      ox      <= 16'd0;
      oy      <= 16'd0;
      k       <= 2'd0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          out_cnt <= 16'd0;
          acc     <= 10'd0;
          ox      <= 16'd0;
          oy      <= 16'd0;
          k       <= 2'd0;
        end
        RD: begin
          // read data lags the strobe by one cycle, so tap k-1 lands here
          if (k != 2'd0) acc <= acc_in;
          k <= k + 2'd1;
        end
        CAP: acc <= acc_in;
        WR: begin
          out_cnt <= out_cnt + 16'd1;
          acc     <= 10'd0;
          k       <= 2'd0;
          if (!last) begin
            if (ox == OX_LAST) begin
              ox <= 16'd0;
              oy <= oy + 16'd1;
            end else begin
              ox <= ox + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ds_pool_engine.sv
// Directed bench for ds_pool_engine on a 4x4 image, plus a second instance with a wrapping source base.
module tb_ds_pool_engine;

  localparam logic [15:0] DST = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_read, mem_write;
  logic [15:0] out_cnt, mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic        busy_w, done_w, rd_w, wr_w;
  logic [15:0] cnt_w, addr_w;
  logic [7:0]  wdata_w, rdata_w;

  logic [7:0]  mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a = 16'd0;
  logic [7:0]  ld_d = 8'd0;

  int n_chk = 0, n_fail = 0;
  int busy_cyc = 0, wr_cnt = 0, done_cnt = 0, overlap = 0;
  logic [15:0] rd_q[$], wa_q[$], rdw_q[$];
  logic [7:0]  wd_q[$];

  always #5 clk = ~clk;

  ds_pool_engine #(.IMG_W(4), .IMG_H(4), .SRC_BASE(16'h0000), .DST_BASE(DST)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .out_cnt(out_cnt),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  ds_pool_engine #(.IMG_W(4), .IMG_H(4), .SRC_BASE(16'hFFFE), .DST_BASE(16'h0100)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_w), .done(done_w), .out_cnt(cnt_w),
    .mem_addr(addr_w), .mem_read(rd_w), .mem_write(wr_w),
    .mem_wdata(wdata_w), .mem_rdata(rdata_w));

  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    if (mem_read) mem_rdata <= mem[mem_addr];
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (rd_w) rdata_w <= addr_w[7:0];
  end

  always @(negedge clk) begin
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (mem_read && mem_write) overlap++;
    if (mem_read) rd_q.push_back(mem_addr);
    if (mem_write) begin
      wr_cnt++;
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (rd_w && rdw_q.size() < 4) rdw_q.push_back(addr_w);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img(input logic [7:0] px [16]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_a = 16'(i); ld_d = px[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_mon();
    busy_cyc = 0; wr_cnt = 0; done_cnt = 0; overlap = 0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
  endtask

  task automatic start_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_run(input string tag, input logic [7:0] exp [4]);
    check({tag, "_busy"}, busy_cyc, 32'd24);
    check({tag, "_writes"}, wr_cnt, 32'd4);
    check({tag, "_done"}, done_cnt, 32'd1);
    check({tag, "_outcnt"}, {16'd0, out_cnt}, 32'd4);
    check({tag, "_overlap"}, overlap, 32'd0);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check({tag, "_waddr"}, {16'd0, wa_q[i]}, {16'd0, DST + 16'(i)});
      check({tag, "_wdata"}, {24'd0, wd_q[i]}, {24'd0, exp[i]});
    end
  endtask

  logic [7:0] img_a [16];
  logic [7:0] img_b [16];
  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];
  logic [7:0] exp_c [4];
  logic [15:0] trace [4];
  int wr_before;

  initial begin
    for (int i = 0; i < 16; i++) img_a[i] = 8'h40;
    img_b = '{8'd1, 8'd2, 8'd255, 8'd255,
              8'd3, 8'd4, 8'd255, 8'd255,
              8'd0, 8'd0, 8'd10,  8'd200,
              8'd0, 8'd1, 8'd30,  8'd40};
    exp_a = '{8'h40, 8'h40, 8'h40, 8'h40};
`ifdef DS_MAX_POOL_EN
    exp_b = '{8'h04, 8'hFF, 8'h01, 8'hC8};
    exp_c = '{8'h04, 8'hFF, 8'h01, 8'hC8};
`else
    exp_b = '{8'h03, 8'hFF, 8'h00, 8'h46};
    exp_c = '{8'h03, 8'hFF, 8'h01, 8'h46};
`endif
    trace = '{16'd2, 16'd3, 16'd6, 16'd7};

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    check("rst_outcnt", {16'd0, out_cnt}, 32'd0);
    rst_n = 1'b1;

    // run A: flat image
    load_img(img_a);
    clear_mon();
    start_run();
    wait_done();
    check_run("flat", exp_a);
    check("wrap_reads", rdw_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < rdw_q.size(); i++) begin
      logic [15:0] wexp [4];
      wexp = '{16'hFFFE, 16'hFFFF, 16'h0002, 16'h0003};
      check("wrap_addr", {16'd0, rdw_q[i]}, {16'd0, wexp[i]});
    end

    // run B: rounding/width blocks, with a stray start mid-run
    load_img(img_b);
    clear_mon();
    start_run();
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check_run("blocks", exp_b);
    check("trace_len", rd_q.size(), 32'd16);
    for (int i = 0; i < 4 && rd_q.size() >= 8; i++)
      check("trace_rd", {16'd0, rd_q[4 + i]}, {16'd0, trace[i]});

    // abort mid-run with reset, then rerun
    img_b[12] = 8'd1;
    load_img(img_b);
    clear_mon();
    start_run();
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("abort_addr", {16'd0, mem_addr}, 32'd0);
    check("abort_outcnt", {16'd0, out_cnt}, 32'd0);
    check("abort_wr_before", wr_cnt, 32'd1);
    wr_before = wr_cnt;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_wr", wr_cnt, wr_before);
    clear_mon();
    start_run();
    wait_done();
    check_run("rerun", exp_c);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
